// File: rtl/arb_pkg.sv
// Shared types, constants and helpers for the main-memory arbiter.
package arb_pkg;

   localparam int NREQ_DEFAULT = 4;
   localparam int WORD_W       = 32;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [WORD_W-1:0] address_t;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
   typedef enum logic       {OP_READ, OP_WRITE} arb_op_t;

   // Successor of idx on a ring of n requesters.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first active requester at or after rr_ptr_i,
// wrapping modulo NREQ.
module rr_picker
   import arb_pkg::*;
#(
   parameter  int NREQ  = NREQ_DEFAULT,
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  active_i,
   input  logic [IDX_W-1:0] rr_ptr_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] winner_o
);

   logic [IDX_W-1:0] idx;

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      valid_o  = |active_i;
      winner_o = rr_ptr_i;
      idx      = '0;
      // Scan offsets from farthest to nearest so the nearest active one is assigned last.
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = IDX_W'((int'(rr_ptr_i) + k) % NREQ);
         if (active_i[idx]) winner_o = idx;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving NREQ requesters one-at-a-time access to single-ported memory.
// Optional macro ARB_TIMEOUT_EN aborts an access after TIMEOUT cycles without mem_ready.
module mem_arbiter
   import arb_pkg::*;
#(
   parameter int NREQ    = NREQ_DEFAULT,
   parameter int ADDR_W  = $bits(address_t),
   parameter int DATA_W  = $bits(word_t),
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     RST,
   input  logic [NREQ-1:0]          req_ren,
   input  logic [NREQ-1:0]          req_wen,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          req_hit,
   output logic [DATA_W-1:0]        req_rdata,
   output logic                     req_err,
   output logic                     mem_ren,
   output logic                     mem_wen,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic                     mem_ready
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   if (NREQ < 2 || TIMEOUT < 1) begin : g_bad_params
      $error("mem_arbiter: NREQ must be >= 2 and TIMEOUT >= 1");
   end

   arb_state_t        state_q, state_d;
   arb_op_t           op_q, op_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [NREQ-1:0]   active;
   logic              pick_valid;
   logic [IDX_W-1:0]  pick_idx;
   logic              timed_out;

   assign active = req_ren | req_wen;

   rr_picker #(.NREQ(NREQ)) u_picker (
      .active_i (active),
      .rr_ptr_i (rr_ptr_q),
      .valid_o  (pick_valid),
      .winner_o (pick_idx)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [CNT_W-1:0] wait_q, wait_d;

   // Counter is zero whenever BUSY is entered because IDLE always clears it.
   always_comb begin
      wait_d    = wait_q;
      timed_out = 1'b0;
      if (state_q == IDLE) begin
         wait_d = '0;
      end else if (state_q == BUSY && !mem_ready) begin
         wait_d    = wait_q + 1'b1;
         timed_out = (wait_d == CNT_W'(TIMEOUT));
      end
   end

   always_ff @(posedge clk) begin
      if (RST) wait_q <= '0;
      else     wait_q <= wait_d;
   end
`else
   assign timed_out = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_d = pick_idx;
               op_d    = req_wen[pick_idx] ? OP_WRITE : OP_READ;
               addr_d  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
               wdata_d = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
               state_d = BUSY;
            end
         end
         BUSY: begin
            // A ready in the same cycle as the timeout wins.
            if (mem_ready) begin
               rdata_d = (op_q == OP_WRITE) ? '0 : mem_rdata;
               state_d = DONE;
            end else if (timed_out) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            rr_ptr_d = IDX_W'(wrap_inc(int'(grant_q), NREQ));
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q  <= IDLE;
         op_q     <= OP_READ;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         // NOTE: datapath registers are reset as well because they drive outputs directly.
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      req_hit = '0;
      if (state_q == DONE) req_hit[grant_q] = 1'b1;
   end

   assign mem_ren   = (state_q == BUSY) && (op_q == OP_READ);
   assign mem_wen   = (state_q == BUSY) && (op_q == OP_WRITE);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign req_rdata = rdata_q;
   assign req_err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized
// traffic checked against a transaction-level round-robin and memory model.
module tb_mem_arbiter;

   localparam int NREQ   = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
`ifdef ARB_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 255;
`endif

   logic                   clk = 1'b0;
   logic                   RST = 1'b1;
   logic [NREQ-1:0]        req_ren, req_wen, req_hit;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_wdata;
   logic [DATA_W-1:0]      req_rdata, mem_wdata, mem_rdata;
   logic [ADDR_W-1:0]      mem_addr;
   logic                   req_err, mem_ren, mem_wen, mem_ready;

   int n_checks = 0;
   int n_fail   = 0;

   bit          d_ren   [NREQ];
   bit          d_wen   [NREQ];
   logic [31:0] d_addr  [NREQ];
   logic [31:0] d_wdata [NREQ];

   // Reference model state for the randomized phase.
   logic [31:0]     mem_m [16];
   logic [NREQ-1:0] pend;
   int              exp_ptr, cur, wait_c, stall, n_hits, nh, busy_n;
   bit              in_txn, hit_due, got_hit;
   logic [31:0]     hit_data;

   mem_arbiter #(
      .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)
   ) dut (
      .clk       (clk),
      .RST       (RST),
      .req_ren   (req_ren),
      .req_wen   (req_wen),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_hit   (req_hit),
      .req_rdata (req_rdata),
      .req_err   (req_err),
      .mem_ren   (mem_ren),
      .mem_wen   (mem_wen),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_ren[i]                       = d_ren[i];
         req_wen[i]                       = d_wen[i];
         req_addr[i*ADDR_W +: ADDR_W]     = d_addr[i];
         req_wdata[i*DATA_W +: DATA_W]    = d_wdata[i];
      end
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < NREQ; i++) begin
         d_ren[i]   = 1'b0;
         d_wen[i]   = 1'b0;
         d_addr[i]  = '0;
         d_wdata[i] = '0;
      end
      drive();
   endtask

   task automatic do_reset(input string tag);
      RST = 1'b1;
      mem_ready = 1'b0;
      clear_reqs();
      tick();
      check({tag, "_ctl"},   {mem_ren, mem_wen, req_hit, req_err}, '0);
      check({tag, "_addr"},  mem_addr, '0);
      check({tag, "_rdata"}, req_rdata, '0);
      RST = 1'b0;
   endtask

   function automatic int pick(input logic [NREQ-1:0] act, input int ptr);
      for (int k = 0; k < NREQ; k++)
         if (act[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      return -1;
   endfunction

   // One cycle of randomized traffic: check outputs against the model, then respond and drive.
   task automatic rnd_cycle(input bit allow_new);
      logic [NREQ-1:0] act;
      bit strobe;
      int just_hit, exp_w, idx;
      tick();
      strobe   = mem_ren | mem_wen;
      just_hit = -1;
      for (int i = 0; i < NREQ; i++) act[i] = d_ren[i] | d_wen[i];
      if (hit_due) begin
         check("rnd_hit", req_hit, 64'(1) << cur);
         check("rnd_rdata", req_rdata, hit_data);
         check("rnd_err", req_err, 0);
         pend[cur] = 1'b0;
         d_ren[cur] = 1'b0;
         d_wen[cur] = 1'b0;
         just_hit = cur;
         exp_ptr = (cur + 1) % NREQ;
         hit_due = 1'b0;
         n_hits++;
      end else if (req_hit != '0) begin
         check("rnd_spurious_hit", req_hit, 0);
      end
      if (in_txn) begin
         check("rnd_strobe_held", strobe, 1);
      end else if (strobe) begin
         exp_w = pick(act, exp_ptr);
         check("rnd_start_valid", exp_w >= 0, 1);
         if (exp_w >= 0) begin
            cur = exp_w;
            in_txn = 1'b1;
            wait_c = 0;
            check("rnd_op", {mem_wen, mem_ren}, d_wen[cur] ? 2'b10 : 2'b01);
            if (d_wen[cur]) check("rnd_wdata", mem_wdata, d_wdata[cur]);
         end
      end
      if (in_txn) begin
         check("rnd_addr", mem_addr, d_addr[cur]);
         wait_c++;
         idx = int'(d_addr[cur][5:2]);
         if (wait_c >= 4 || $urandom_range(0, 1) == 1) begin
            mem_ready = 1'b1;
            if (d_wen[cur]) begin
               mem_rdata  = $urandom;
               hit_data   = '0;
               mem_m[idx] = d_wdata[cur];
            end else begin
               mem_rdata = mem_m[idx];
               hit_data  = mem_m[idx];
            end
            hit_due = 1'b1;
            in_txn  = 1'b0;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
         end
      end else begin
         mem_ready = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
      end
      if (act != '0 && !strobe) stall++;
      else stall = 0;
      if (stall > 3) begin
         check("rnd_stall", stall, 0);
         stall = 0;
      end
      if (allow_new) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && i != just_hit && $urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1;
               case ($urandom_range(0, 3))
                  0:       begin d_ren[i] = 1'b0; d_wen[i] = 1'b1; end
                  1:       begin d_ren[i] = 1'b1; d_wen[i] = 1'b1; end
                  default: begin d_ren[i] = 1'b1; d_wen[i] = 1'b0; end
               endcase
               d_addr[i]  = 32'($urandom_range(0, 15)) << 2;
               d_wdata[i] = $urandom;
            end
         end
      end
      drive();
   endtask

   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      clear_reqs();
      do_reset("init");

      // Single read, ready on the second BUSY cycle.
      d_ren[1] = 1'b1; d_addr[1] = 32'h40; drive();
      tick();
      check("rd_strobe1", {mem_ren, mem_wen}, 2'b10);
      check("rd_addr", mem_addr, 32'h40);
      check("rd_nohit", req_hit, 0);
      tick();
      check("rd_strobe2", {mem_ren, mem_wen}, 2'b10);
      mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      check("rd_done_strobe", {mem_ren, mem_wen}, 2'b00);
      check("rd_hit", req_hit, 4'b0010);
      check("rd_rdata", req_rdata, 32'hDEAD_BEEF);
      d_ren[1] = 1'b0; drive(); mem_ready = 1'b0; mem_rdata = 32'h0BAD_0BAD;
      tick();
      check("rd_hit_once", req_hit, 0);
      check("rd_rdata_hold", req_rdata, 32'hDEAD_BEEF);

      // Round robin with all requesters held and memory always ready.
      do_reset("rr");
      for (int i = 0; i < NREQ; i++) begin
         d_ren[i] = 1'b1; d_addr[i] = 32'h100 + 32'(4 * i);
      end
      drive(); mem_ready = 1'b1; mem_rdata = 32'h1111_0000;
      nh = 0;
      for (int c = 1; c <= 15; c++) begin
         tick();
         if (req_hit != '0) begin
            check("rr_grant", req_hit, 64'(1) << (nh % NREQ));
            check("rr_cycle", c, 2 + 3 * nh);
            nh++;
         end
      end
      check("rr_count", nh, 5);
      clear_reqs(); mem_ready = 1'b0;
      tick(); tick();

      // Write wins when both read and write are requested.
      d_ren[2] = 1'b1; d_wen[2] = 1'b1; d_addr[2] = 32'h80; d_wdata[2] = 32'h1234_5678; drive();
      tick();
      check("wr_strobe", {mem_ren, mem_wen}, 2'b01);
      check("wr_addr", mem_addr, 32'h80);
      check("wr_wdata", mem_wdata, 32'h1234_5678);
      mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      tick();
      check("wr_hit", req_hit, 4'b0100);
      check("wr_rdata_zero", req_rdata, 0);
      clear_reqs(); mem_ready = 1'b0;
      tick();

      // Requester drops during BUSY; access still completes and hits.
      do_reset("drop");
      d_ren[3] = 1'b1; d_addr[3] = 32'hC0; drive();
      tick();
      check("drop_addr1", mem_addr, 32'hC0);
      d_ren[3] = 1'b0; d_ren[1] = 1'b1; d_addr[1] = 32'h44; drive();
      tick();
      check("drop_strobe", {mem_ren, mem_wen}, 2'b10);
      check("drop_addr2", mem_addr, 32'hC0);
      mem_ready = 1'b1; mem_rdata = 32'h3333_3333;
      tick();
      check("drop_hit", req_hit, 4'b1000);
      check("drop_rdata", req_rdata, 32'h3333_3333);
      mem_ready = 1'b0;
      tick();
      check("drop_idle", {mem_ren, mem_wen, req_hit}, 0);
      tick();
      check("drop_next_strobe", {mem_ren, mem_wen}, 2'b10);
      check("drop_next_addr", mem_addr, 32'h44);
      mem_ready = 1'b1; mem_rdata = 32'h4444_4444;
      tick();
      check("drop_next_hit", req_hit, 4'b0010);
      clear_reqs(); mem_ready = 1'b0;
      tick();

      // Reset in the middle of BUSY; pointer returns to 0.
      d_ren[0] = 1'b1; d_addr[0] = 32'h10; d_ren[2] = 1'b1; d_addr[2] = 32'h20; drive();
      tick();
      check("mid_pre_addr", mem_addr, 32'h20);
      RST = 1'b1;
      tick();
      check("mid_rst_ctl", {mem_ren, mem_wen, req_hit, req_err}, 0);
      check("mid_rst_addr", mem_addr, 0);
      check("mid_rst_rdata", req_rdata, 0);
      RST = 1'b0;
      tick();
      check("mid_regrant_addr", mem_addr, 32'h10);
      check("mid_regrant_nohit", req_hit, 0);
      mem_ready = 1'b1; mem_rdata = 32'hA5A5_0000;
      tick();
      check("mid_hit0", req_hit, 4'b0001);
      d_ren[0] = 1'b0; drive(); mem_ready = 1'b0;
      tick(); tick();
      check("mid_second_addr", mem_addr, 32'h20);
      mem_ready = 1'b1; mem_rdata = 32'h5A5A_5A5A;
      tick();
      check("mid_hit2", req_hit, 4'b0100);
      clear_reqs(); mem_ready = 1'b0;
      tick();

      // Memory never ready.
      d_ren[1] = 1'b1; d_addr[1] = 32'h50; drive();
      busy_n = 0;
`ifdef ARB_TIMEOUT_EN
      got_hit = 1'b0;
      for (int c = 0; c < 20 && !got_hit; c++) begin
         tick();
         if (mem_ren) busy_n++;
         if (req_hit != '0) begin
            got_hit = 1'b1;
            check("tmo_hit", req_hit, 4'b0010);
            check("tmo_err", req_err, 1);
            check("tmo_rdata", req_rdata, 0);
         end
      end
      check("tmo_seen", got_hit, 1);
      check("tmo_busy_cycles", busy_n, TMO);
      clear_reqs();
      tick();
      check("tmo_err_clear", {req_err, req_hit}, 0);
`else
      for (int c = 0; c < 300; c++) begin
         tick();
         if (mem_ren && mem_addr == 32'h50 && req_hit == '0 && !req_err) busy_n++;
      end
      check("hold_cycles", busy_n, 300);
      clear_reqs(); mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
      tick();
      check("hold_hit", req_hit, 4'b0010);
      check("hold_err", req_err, 0);
      mem_ready = 1'b0;
      tick();
`endif

      // Randomized traffic against the reference model.
      do_reset("rnd");
      for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
      pend = '0; exp_ptr = 0; cur = 0; in_txn = 1'b0; hit_due = 1'b0;
      stall = 0; n_hits = 0; hit_data = '0;
      for (int c = 0; c < 3000; c++) rnd_cycle(1'b1);
      for (int c = 0; c < 100 && (pend != '0 || in_txn || hit_due); c++) rnd_cycle(1'b0);
      check("rnd_drained", {pend != '0, in_txn, hit_due}, 0);
      check("rnd_activity", n_hits > 100, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates single-ported main memory between NREQ requesters: per-core instruction and data request ports (two cores → NREQ=4).
- Sits between the per-core request units/caches and the RAM controller.
- Round-robin grant; one outstanding memory transaction at a time; each requester gets a one-cycle hit pulse on completion.

Parameters:
NREQ, 4, number of requester ports (≥2)
ADDR_W, 32, address width
DATA_W, 32, data word width
TIMEOUT, 255, max cycles to wait for mem_ready (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
RST  in  1  reset, synchronous, active-high
req_ren  in  NREQ  per-requester read request, held until hit
req_wen  in  NREQ  per-requester write request, held until hit
req_addr  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NREQ*DATA_W  packed store data
req_hit  out  NREQ  one-hot completion pulse
req_rdata  out  DATA_W  load data, valid while req_hit nonzero
req_err  out  1  timeout abort pulse (0 without ARB_TIMEOUT_EN)
mem_ren  out  1  memory read strobe
mem_wen  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory store data
mem_rdata  in  DATA_W  memory load data, valid with mem_ready
mem_ready  in  1  memory completed current access this cycle

Behaviour:
- Reset (RST=1 at an edge), including mid-transaction: state IDLE, rr_ptr=0, all outputs 0, grant cleared; in-flight access abandoned, no hit issued.
- Requester i active = req_ren[i] | req_wen[i]. If both set, write performed (req_wen wins).
- Round-robin pick: first active index scanning rr_ptr, rr_ptr+1, … mod NREQ.
- IDLE:
  - No active requester → stay.
  - Otherwise latch winner id, op, addr and wdata into registers; → BUSY.
- BUSY:
  - mem_ren/mem_wen/mem_addr/mem_wdata driven from latched registers (first strobe one cycle after the request is seen in IDLE).
  - Values held stable regardless of requester inputs.
  - On mem_ready=1: capture mem_rdata into req_rdata (writes capture 0); → DONE.
- DONE (one cycle):
  - mem_ren=mem_wen=0.
  - req_hit[grant]=1, all other bits 0.
  - rr_ptr ← (grant+1) mod NREQ; → IDLE.
- req_rdata holds its last value outside DONE; only meaningful with hit.
- Minimum transaction: 3 cycles (IDLE→BUSY→DONE) with mem_ready in the first BUSY cycle.
- Requester must drop its request on the edge after its hit. IDLE then samples updated inputs, so no duplicate grant.
- Requester deasserting during BUSY: access still completes and the hit still pulses. Memory ops are never cancelled.
- mem_ready outside BUSY: ignored.
- Starvation bound: any held request is granted within NREQ transactions.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - 8-bit-or-wider wait counter cleared on entry to BUSY, incremented each BUSY cycle without mem_ready.
  - On reaching TIMEOUT: → DONE with req_hit[grant]=1, req_err=1 and req_rdata=0 for that cycle; rr_ptr advances normally.
  - mem_ready in the same cycle as the counter reaching TIMEOUT: treated as success.
- Not defined: no counter; BUSY waits indefinitely; req_err tied 0.

Decomposition:
- Package arb_pkg:
  - state enum arb_state_t {IDLE, BUSY, DONE}
  - op enum arb_op_t {OP_READ, OP_WRITE}
  - default NREQ constant
  - word_t/address types reused from cpu_types_pkg
- Sub-module rr_picker, purely combinational:
  - inputs: active vector, rr_ptr
  - outputs: valid, winner index

Test Plan:
- Single read: req_ren[1]=1, addr 0x40; mem_ready pulses with rdata 0xDEADBEEF on 2nd BUSY cycle → mem_ren high 2 cycles at 0x40, then req_hit=4'b0010, req_rdata=0xDEADBEEF for exactly 1 cycle.
- Round-robin: all four requesters held active from reset, mem_ready always 1 → grants in order 0,1,2,3,0, each hit 3 cycles apart.
- Write priority and data: req_ren[2]=req_wen[2]=1, wdata 0x12345678, addr 0x80 → mem_wen=1, mem_ren=0, mem_wdata=0x12345678, mem_addr=0x80; hit on bit 2.
- Drop during BUSY: requester 3 deasserts after grant → access completes, req_hit[3] still pulses, next grant goes to the next active requester at index ≥0 from rr_ptr=0.
- Reset mid-BUSY: assert RST for one cycle while mem_ren=1 → next cycle all outputs 0, no hit; subsequent request granted starting from index 0.
- ARB_TIMEOUT_EN, TIMEOUT=8, mem_ready held 0 → after 8 BUSY cycles req_err=1 and req_hit pulses with req_rdata=0; without the macro, mem_ren stays high indefinitely.
